// File: rtl/pic_inta_sequencer.sv
// 8259 PIC CPU-side interrupt acknowledge sequencer (8086 mode).
// Resolves fixed priority over unmasked requests in fully nested mode, runs the
// two-pulse INTA handshake, drives the vector byte and owns the in-service register.
module pic_inta_sequencer #(
    parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] interrupt_request,
    input  logic [7:0] interrupt_mask,
    input  logic       inta_n,
    input  logic [4:0] vector_base,
    input  logic       auto_eoi,
    input  logic       eoi_cmd,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    output logic       int_out,
    output logic [7:0] irr_clear,
    output logic [7:0] data_out,
    output logic       data_out_en,
    output logic [7:0] in_service_register
);

    typedef enum logic [1:0] {StIdle, StIntPend, StAck1, StAck2} state_e;

    state_e     state_q;
    logic       inta_q;
    logic [2:0] lvl_q;
    logic       spur_q;

    logic       fall;
    logic       rise;
    logic [7:0] pend;
    logic [2:0] req_lvl;
    logic [2:0] isr_lvl;
    logic       eligible;
    logic [7:0] isr_set;
    logic [7:0] isr_clr;

    assign fall = inta_q & ~inta_n;
    assign rise = ~inta_q & inta_n;
    assign pend = interrupt_request & ~interrupt_mask;

    // Priority encoders: lowest set index wins (IR0 highest priority).
    always_comb begin
        req_lvl = 3'd0;
        isr_lvl = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pend[i]) req_lvl = 3'(i);
            if (in_service_register[i]) isr_lvl = 3'(i);
        end
    end

    // Fully nested: only a strictly higher-priority request may interrupt service.
    always_comb begin
        eligible = (pend != 8'h00) &&
                   ((in_service_register == 8'h00) || (req_lvl < isr_lvl));
    end

    // ISR set/clear masks; EOI decodes against the pre-update ISR.
    always_comb begin
        isr_set = 8'h00;
        isr_clr = 8'h00;
        if ((state_q == StIntPend) && fall && (pend != 8'h00)) begin
            isr_set[req_lvl] = 1'b1;
        end
        if ((state_q == StAck2) && rise && auto_eoi && !spur_q) begin
            isr_clr[lvl_q] = 1'b1;
        end
        if (eoi_cmd) begin
            if (eoi_specific) begin
                isr_clr[eoi_level] = 1'b1;
            end else if (in_service_register != 8'h00) begin
                isr_clr[isr_lvl] = 1'b1;
            end
        end
    end

    // Handshake FSM with registered outputs; a set beats a clear on the same ISR bit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q             <= StIdle;
            inta_q              <= 1'b1;
            lvl_q               <= 3'd0;
            spur_q              <= 1'b0;
            int_out             <= 1'b0;
            irr_clear           <= 8'h00;
            data_out            <= 8'h00;
            data_out_en         <= 1'b0;
            in_service_register <= 8'h00;
        end else begin
            inta_q              <= inta_n;
            irr_clear           <= 8'h00;
            in_service_register <= (in_service_register & ~isr_clr) | isr_set;
            case (state_q)
                StIdle: begin
                    if (eligible) begin
                        state_q <= StIntPend;
                        int_out <= 1'b1;
                    end
                end
                StIntPend: begin
                    if (fall) begin
                        lvl_q     <= (pend != 8'h00) ? req_lvl : SPURIOUS_LEVEL;
                        spur_q    <= (pend == 8'h00);
                        irr_clear <= isr_set;
                        state_q   <= StAck1;
                    end else if (!eligible) begin
                        state_q <= StIdle;
                        int_out <= 1'b0;
                    end
                end
                StAck1: begin
                    if (fall) begin
                        data_out    <= {vector_base, lvl_q};
                        data_out_en <= 1'b1;
                        state_q     <= StAck2;
                    end
                end
                StAck2: begin
                    if (rise) begin
                        data_out_en <= 1'b0;
                        int_out     <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Self-checking bench for pic_inta_sequencer: table-driven vectors plus hand-written
// multi-cycle sequences, with expected outputs queued at drive time.
module tb_pic_inta_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] interrupt_request;
    logic [7:0] interrupt_mask;
    logic       inta_n;
    logic [4:0] vector_base;
    logic       auto_eoi;
    logic       eoi_cmd;
    logic       eoi_specific;
    logic [2:0] eoi_level;
    logic       int_out;
    logic [7:0] irr_clear;
    logic [7:0] data_out;
    logic       data_out_en;
    logic [7:0] in_service_register;

    pic_inta_sequencer dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .interrupt_request   (interrupt_request),
        .interrupt_mask      (interrupt_mask),
        .inta_n              (inta_n),
        .vector_base         (vector_base),
        .auto_eoi            (auto_eoi),
        .eoi_cmd             (eoi_cmd),
        .eoi_specific        (eoi_specific),
        .eoi_level           (eoi_level),
        .int_out             (int_out),
        .irr_clear           (irr_clear),
        .data_out            (data_out),
        .data_out_en         (data_out_en),
        .in_service_register (in_service_register)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst_n;
        logic [7:0] irq;
        logic [7:0] mask;
        logic       inta;
        logic [4:0] base;
        logic       aeoi;
        logic       eoi;
        logic       spec;
        logic [2:0] elvl;
        logic       e_int;
        logic [7:0] e_clr;
        logic [7:0] e_dout;
        logic       e_en;
        logic [7:0] e_isr;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input string n, input logic r, input logic [7:0] irq,
                                input logic [7:0] mask, input logic inta,
                                input logic [4:0] base, input logic aeoi, input logic eoi,
                                input logic spec, input logic [2:0] elvl,
                                input logic e_int, input logic [7:0] e_clr,
                                input logic [7:0] e_dout, input logic e_en,
                                input logic [7:0] e_isr);
        vec_t v;
        v.name = n;    v.rst_n = r;    v.irq = irq;      v.mask = mask;  v.inta = inta;
        v.base = base; v.aeoi = aeoi;  v.eoi = eoi;      v.spec = spec;  v.elvl = elvl;
        v.e_int = e_int; v.e_clr = e_clr; v.e_dout = e_dout; v.e_en = e_en; v.e_isr = e_isr;
        return v;
    endfunction

    task automatic check_out();
        vec_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard: no expected entry queued");
            return;
        end
        e = exp_q.pop_front();
        if (int_out !== e.e_int || irr_clear !== e.e_clr || data_out !== e.e_dout ||
            data_out_en !== e.e_en || in_service_register !== e.e_isr) begin
            n_err++;
            $display("FAIL %s: got int=%0b clr=%02h dout=%02h en=%0b isr=%02h, want int=%0b clr=%02h dout=%02h en=%0b isr=%02h",
                     e.name, int_out, irr_clear, data_out, data_out_en, in_service_register,
                     e.e_int, e.e_clr, e.e_dout, e.e_en, e.e_isr);
        end
    endtask

    task automatic apply(input vec_t v);
        reset_n           = v.rst_n;
        interrupt_request = v.irq;
        interrupt_mask    = v.mask;
        inta_n            = v.inta;
        vector_base       = v.base;
        auto_eoi          = v.aeoi;
        eoi_cmd           = v.eoi;
        eoi_specific      = v.spec;
        eoi_level         = v.elvl;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        // Reset, then basic handshake at IR3 with base 0x08
        vecs.push_back(mk("rst0",     0, 8'h00, 8'h00, 1, 5'h08, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00));
        vecs.push_back(mk("rst1",     0, 8'h08, 8'h00, 0, 5'h08, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00));
        vecs.push_back(mk("t1_int",   1, 8'h08, 8'h00, 1, 5'h08, 0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 8'h00));
        vecs.push_back(mk("t1_ack1",  1, 8'h08, 8'h00, 0, 5'h08, 0, 0, 0, 0, 1, 8'h08, 8'h00, 0, 8'h08));
        vecs.push_back(mk("t1_hold",  1, 8'h00, 8'h00, 0, 5'h08, 0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 8'h08));
        vecs.push_back(mk("t1_rise1", 1, 8'h00, 8'h00, 1, 5'h08, 0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 8'h08));
        vecs.push_back(mk("t1_vec",   1, 8'h00, 8'h00, 0, 5'h08, 0, 0, 0, 0, 1, 8'h00, 8'h43, 1, 8'h08));
        vecs.push_back(mk("t1_vhold", 1, 8'h00, 8'h00, 0, 5'h08, 0, 0, 0, 0, 1, 8'h00, 8'h43, 1, 8'h08));
        vecs.push_back(mk("t1_rise2", 1, 8'h00, 8'h00, 1, 5'h08, 0, 0, 0, 0, 0, 8'h00, 8'h43, 0, 8'h08));
        vecs.push_back(mk("t1_idle",  1, 8'h00, 8'h00, 1, 5'h08, 0, 0, 0, 0, 0, 8'h00, 8'h43, 0, 8'h08));
        // Nesting: IR1 interrupts IR3 service, then two non-specific EOIs
        vecs.push_back(mk("t2_int",   1, 8'h22, 8'h00, 1, 5'h08, 0, 0, 0, 0, 1, 8'h00, 8'h43, 0, 8'h08));
        vecs.push_back(mk("t2_ack1",  1, 8'h22, 8'h00, 0, 5'h08, 0, 0, 0, 0, 1, 8'h02, 8'h43, 0, 8'h0a));
        vecs.push_back(mk("t2_rise1", 1, 8'h20, 8'h00, 1, 5'h08, 0, 0, 0, 0, 1, 8'h00, 8'h43, 0, 8'h0a));
        vecs.push_back(mk("t2_vec",   1, 8'h20, 8'h00, 0, 5'h08, 0, 0, 0, 0, 1, 8'h00, 8'h41, 1, 8'h0a));
        vecs.push_back(mk("t2_rise2", 1, 8'h20, 8'h00, 1, 5'h08, 0, 0, 0, 0, 0, 8'h00, 8'h41, 0, 8'h0a));
        vecs.push_back(mk("t2_eoi1",  1, 8'h20, 8'h00, 1, 5'h08, 0, 1, 0, 0, 0, 8'h00, 8'h41, 0, 8'h08));
        vecs.push_back(mk("t2_blk",   1, 8'h20, 8'h00, 1, 5'h08, 0, 0, 0, 0, 0, 8'h00, 8'h41, 0, 8'h08));
        vecs.push_back(mk("t2_eoi2",  1, 8'h20, 8'h00, 1, 5'h08, 0, 1, 0, 0, 0, 8'h00, 8'h41, 0, 8'h00));
        vecs.push_back(mk("t2_reint", 1, 8'h20, 8'h00, 1, 5'h08, 0, 0, 0, 0, 1, 8'h00, 8'h41, 0, 8'h00));
        vecs.push_back(mk("t2_drop",  1, 8'h00, 8'h00, 1, 5'h08, 0, 0, 0, 0, 0, 8'h00, 8'h41, 0, 8'h00));
        // Blocking: IR2 in service blocks IR4 until a specific EOI for level 2
        vecs.push_back(mk("t3_int",   1, 8'h04, 8'h00, 1, 5'h08, 0, 0, 0, 0, 1, 8'h00, 8'h41, 0, 8'h00));
        vecs.push_back(mk("t3_ack1",  1, 8'h04, 8'h00, 0, 5'h08, 0, 0, 0, 0, 1, 8'h04, 8'h41, 0, 8'h04));
        vecs.push_back(mk("t3_rise1", 1, 8'h00, 8'h00, 1, 5'h08, 0, 0, 0, 0, 1, 8'h00, 8'h41, 0, 8'h04));
        vecs.push_back(mk("t3_vec",   1, 8'h00, 8'h00, 0, 5'h08, 0, 0, 0, 0, 1, 8'h00, 8'h42, 1, 8'h04));
        vecs.push_back(mk("t3_rise2", 1, 8'h00, 8'h00, 1, 5'h08, 0, 0, 0, 0, 0, 8'h00, 8'h42, 0, 8'h04));
        vecs.push_back(mk("t3_blk1",  1, 8'h10, 8'h00, 1, 5'h08, 0, 0, 0, 0, 0, 8'h00, 8'h42, 0, 8'h04));
        vecs.push_back(mk("t3_blk2",  1, 8'h10, 8'h00, 1, 5'h08, 0, 0, 0, 0, 0, 8'h00, 8'h42, 0, 8'h04));
        vecs.push_back(mk("t3_seoi",  1, 8'h10, 8'h00, 1, 5'h08, 0, 1, 1, 2, 0, 8'h00, 8'h42, 0, 8'h00));
        vecs.push_back(mk("t3_int2",  1, 8'h10, 8'h00, 1, 5'h08, 0, 0, 0, 0, 1, 8'h00, 8'h42, 0, 8'h00));
        vecs.push_back(mk("t3_drop",  1, 8'h00, 8'h00, 1, 5'h08, 0, 0, 0, 0, 0, 8'h00, 8'h42, 0, 8'h00));
        // Spurious: request vanishes as the first INTA falls
        vecs.push_back(mk("t4_int",   1, 8'h01, 8'h00, 1, 5'h08, 0, 0, 0, 0, 1, 8'h00, 8'h42, 0, 8'h00));
        vecs.push_back(mk("t4_spur",  1, 8'h00, 8'h00, 0, 5'h08, 0, 0, 0, 0, 1, 8'h00, 8'h42, 0, 8'h00));
        vecs.push_back(mk("t4_rise1", 1, 8'h00, 8'h00, 1, 5'h08, 0, 0, 0, 0, 1, 8'h00, 8'h42, 0, 8'h00));
        vecs.push_back(mk("t4_vec",   1, 8'h00, 8'h00, 0, 5'h08, 0, 0, 0, 0, 1, 8'h00, 8'h47, 1, 8'h00));
        vecs.push_back(mk("t4_rise2", 1, 8'h00, 8'h00, 1, 5'h08, 0, 0, 0, 0, 0, 8'h00, 8'h47, 0, 8'h00));
        // Auto-EOI at IR7 with base 0x12
        vecs.push_back(mk("t5_int",   1, 8'h80, 8'h00, 1, 5'h12, 1, 0, 0, 0, 1, 8'h00, 8'h47, 0, 8'h00));
        vecs.push_back(mk("t5_ack1",  1, 8'h80, 8'h00, 0, 5'h12, 1, 0, 0, 0, 1, 8'h80, 8'h47, 0, 8'h80));
        vecs.push_back(mk("t5_rise1", 1, 8'h00, 8'h00, 1, 5'h12, 1, 0, 0, 0, 1, 8'h00, 8'h47, 0, 8'h80));
        vecs.push_back(mk("t5_vec",   1, 8'h00, 8'h00, 0, 5'h12, 1, 0, 0, 0, 1, 8'h00, 8'h97, 1, 8'h80));
        vecs.push_back(mk("t5_rise2", 1, 8'h00, 8'h00, 1, 5'h12, 1, 0, 0, 0, 0, 8'h00, 8'h97, 0, 8'h00));

        reset_n = 1'b0; interrupt_request = 8'h00; interrupt_mask = 8'h00; inta_n = 1'b1;
        vector_base = 5'h08; auto_eoi = 1'b0; eoi_cmd = 1'b0; eoi_specific = 1'b0;
        eoi_level = 3'd0;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // Reset in ACK2 with the vector on the bus; INT re-raised afterwards, fall in IDLE ignored
        apply(mk("t6_int",    1, 8'h02, 8'h00, 1, 5'h08, 0, 0, 0, 0, 1, 8'h00, 8'h97, 0, 8'h00));
        apply(mk("t6_ack1",   1, 8'h02, 8'h00, 0, 5'h08, 0, 0, 0, 0, 1, 8'h02, 8'h97, 0, 8'h02));
        apply(mk("t6_rise1",  1, 8'h02, 8'h00, 1, 5'h08, 0, 0, 0, 0, 1, 8'h00, 8'h97, 0, 8'h02));
        apply(mk("t6_vec",    1, 8'h02, 8'h00, 0, 5'h08, 0, 0, 0, 0, 1, 8'h00, 8'h41, 1, 8'h02));
        apply(mk("t6_rst",    0, 8'h02, 8'h00, 0, 5'h08, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00));
        apply(mk("t6_reint",  1, 8'h02, 8'h00, 0, 5'h08, 0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 8'h00));
        apply(mk("t6_rise",   1, 8'h02, 8'h00, 1, 5'h08, 0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 8'h00));
        // Set and specific EOI clear of the same bit in one cycle: bit stays set
        apply(mk("t7_setclr", 1, 8'h02, 8'h00, 0, 5'h08, 0, 1, 1, 1, 1, 8'h02, 8'h00, 0, 8'h02));
        apply(mk("t7_rise1",  1, 8'h00, 8'h00, 1, 5'h08, 0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 8'h02));
        apply(mk("t7_vec",    1, 8'h00, 8'h00, 0, 5'h08, 0, 0, 0, 0, 1, 8'h00, 8'h41, 1, 8'h02));
        apply(mk("t7_rise2",  1, 8'h00, 8'h00, 1, 5'h08, 0, 0, 0, 0, 0, 8'h00, 8'h41, 0, 8'h02));
        // Non-specific EOI on the first-INTA fall uses pre-update ISR; masking mid-cycle ignored
        apply(mk("t8_int",    1, 8'h01, 8'h00, 1, 5'h08, 0, 0, 0, 0, 1, 8'h00, 8'h41, 0, 8'h02));
        apply(mk("t8_col",    1, 8'h01, 8'h00, 0, 5'h08, 0, 1, 0, 0, 1, 8'h01, 8'h41, 0, 8'h01));
        apply(mk("t8_mask",   1, 8'h00, 8'hff, 1, 5'h08, 0, 0, 0, 0, 1, 8'h00, 8'h41, 0, 8'h01));
        apply(mk("t8_vec",    1, 8'h00, 8'hff, 0, 5'h08, 0, 0, 0, 0, 1, 8'h00, 8'h40, 1, 8'h01));
        apply(mk("t8_rise2",  1, 8'h00, 8'hff, 1, 5'h08, 0, 0, 0, 0, 0, 8'h00, 8'h40, 0, 8'h01));
        apply(mk("t8_seoi",   1, 8'h00, 8'h00, 1, 5'h08, 0, 1, 1, 0, 0, 8'h00, 8'h40, 0, 8'h00));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
